t_event_decoder: RTL and testbench
==================================

# t_event_decoder

Receive side of the toggle-encoded event link. The transmit side is a T-type latch/flop whose output flips once per event. This block takes that toggle line, which is asynchronous to `clk`, and synchronizes it. It then turns each level change back into a one-cycle event pulse, queues pending events in a saturating counter behind a valid/ready handshake, and keeps a wrapping total-event count plus a sticky overflow flag.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `tog_in`; legal values ≥2.
- `CNT_W`, 4: pending-event counter width; maximum pending is 2^CNT_W−1.
- `TOT_W`, 8: total-event counter width; wraps modulo 2^TOT_W.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset; every register clears immediately on assertion.
- `tog_in`, input, 1: toggle line from the encoder; asynchronous to `clk`; each level change is one event.
- `clr`, input, 1: synchronous clear of `pend_cnt`, `evt_total` and `ovf`.
- `evt_ready`, input, 1: consumer accepts one pending event when high together with `evt_valid`.
- `tog_level`, output, 1: synchronized level of `tog_in`.
- `evt_pulse`, output, 1: high for exactly one cycle per detected toggle.
- `evt_valid`, output, 1: high while `pend_cnt` != 0.
- `pend_cnt`, output, CNT_W: number of events not yet consumed.
- `evt_total`, output, TOT_W: events detected since reset or `clr`.
- `ovf`, output, 1: sticky; an event was dropped because `pend_cnt` was saturated.

## Operation
- Synchronizer:
  - `tog_in` passes through flops s[0]..s[SYNC_STAGES−1].
  - `tog_level` = s[SYNC_STAGES−1].
- Edge detector:
  - Register `prev` loads `tog_level` every cycle.
  - `evt_pulse` = `tog_level` XOR `prev` (combinational from flops; glitch-free).
  - Rising and falling edges of the toggle line both count as one event.
- Pending counter (`inc` = `evt_pulse`, `dec` = `evt_valid` AND `evt_ready`):
  - `inc` only, `pend_cnt` below max: +1.
  - `inc` only, `pend_cnt` at max: count held, event dropped, `ovf` set to 1.
  - `dec` only: −1.
  - `inc` and `dec` together: unchanged, including at max; no overflow in that case.
  - Neither: held.
- `evt_total` increments on every `evt_pulse`, including dropped events. It wraps from 2^TOT_W−1 to 0.
- `clr` has priority over everything in the same cycle:
  - `pend_cnt`, `evt_total` and `ovf` all go to 0.
  - A coincident `evt_pulse` is discarded and not counted.
  - A coincident `dec` is ignored.
  - The synchronizer and `prev` keep running, so `clr` never creates or hides later edges.
- Sticky `ovf`: once set, it stays 1 until `clr` or reset.

## Timing
- Reset values (applied immediately on `rst_n` low):
  - All of s[], `prev`, `tog_level`, `evt_pulse`, `evt_valid`, `pend_cnt`, `evt_total` and `ovf` are 0.
- Line high at reset release: the encoder's reset state is defined as 0. If `tog_in` is 1 when `rst_n` rises, one event is detected SYNC_STAGES cycles later. This is required behaviour.
- Detection latency:
  - A `tog_in` change captured by s[0] at edge k makes `tog_level` change after edge k+SYNC_STAGES−1.
  - `evt_pulse` is high for the following cycle only.
  - `pend_cnt`, `evt_valid` and `evt_total` update at edge k+SYNC_STAGES.
- Handshake:
  - A transfer completes at a rising edge where `evt_valid` and `evt_ready` are both high.
  - `evt_valid` may drop only as a result of a transfer or `clr`.
  - `evt_ready` may be held high continuously.
- Throughput: toggles spaced ≥2 cycles apart are all detected. Faster toggling is outside the link contract; events may merge.
- Reset mid-operation: all state is lost immediately; no event is emitted for the reset itself.

## Test plan
- Reset, then toggle `tog_in` 0→1 with `evt_ready`=0 → exactly one `evt_pulse`, 2 cycles after capture; `pend_cnt`=1, `evt_valid`=1, `evt_total`=1.
- 3 more toggles, 4 cycles apart, `evt_ready`=0; then hold `evt_ready`=1 → `pend_cnt` reaches 4, then decrements one per cycle to 0; `evt_valid` falls when the count reaches 0; `evt_total`=4.
- With `CNT_W`=4 and `evt_ready`=0, send 17 toggles → `pend_cnt` saturates at 15; `ovf`=1 after the 16th; `evt_total`=17. Then assert `clr` 1 cycle → all three are 0.
- `pend_cnt`=15, `evt_ready`=1, and a toggle arriving in the same cycle → `pend_cnt` stays 15 and `ovf` stays 0.
- `clr` asserted in the exact `evt_pulse` cycle → counters are 0 and the event is not counted. A toggle 4 cycles later counts normally (`pend_cnt`=1).
- `tog_in`=1 during reset; assert `rst_n` low mid-queue with `pend_cnt`=3 → outputs go to 0 at once. After release, exactly one event is detected.

Source files
------------

// File: rtl/t_event_decoder.sv
// Receive side of the toggle-encoded event link: synchronizes the toggle line,
// turns each level change into a one-cycle pulse and queues events behind valid/ready.
module t_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             tog_level,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [TOT_W-1:0] evt_total,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic [TOT_W-1:0]       tot_q, tot_d;
    logic                   ovf_q, ovf_d;
    logic                   inc, dec;

    // Synchronizer and edge-detect history run independently of clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tog_level = sync_q[SYNC_STAGES-1];
    assign evt_pulse = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign evt_valid = (pend_q != '0);
    assign inc       = evt_pulse;
    assign dec       = evt_valid & evt_ready;

    always_comb begin
        pend_d = pend_q;
        tot_d  = tot_q;
        ovf_d  = ovf_q;
        if (clr) begin
            pend_d = '0;
            tot_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (inc) begin
                tot_d = tot_q + TOT_W'(1);
            end
            // Simultaneous inc and dec cancel, so a saturated queue never overflows then.
            case ({inc, dec})
                2'b10: begin
                    if (pend_q == PEND_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + CNT_W'(1);
                    end
                end
                2'b01:   pend_d = pend_q - CNT_W'(1);
                default: pend_d = pend_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            tot_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tot_q  <= tot_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_cnt  = pend_q;
    assign evt_total = tot_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_t_event_decoder.sv
// Directed bench for t_event_decoder with hand-computed expectations.
module tb_t_event_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tog_in;
    logic       clr;
    logic       evt_ready;
    logic       tog_level;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pend_cnt;
    logic [7:0] evt_total;
    logic       ovf;

    int n_chk = 0;
    int n_err = 0;
    int pulses;

    t_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .clr       (clr),
        .evt_ready (evt_ready),
        .tog_level (tog_level),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .evt_total (evt_total),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] p, input logic [7:0] t,
                              input logic o);
        check_eq({tag, ".pend"},  32'(pend_cnt),  32'(p));
        check_eq({tag, ".valid"}, 32'(evt_valid), 32'(p != 4'd0));
        check_eq({tag, ".total"}, 32'(evt_total), 32'(t));
        check_eq({tag, ".ovf"},   32'(ovf),       32'(o));
    endtask

    initial begin
        rst_n = 1'b0; tog_in = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        tick(3);
        check_outs("reset", 4'd0, 8'd0, 1'b0);
        check_eq("reset.level", 32'(tog_level), 32'd0);
        check_eq("reset.pulse", 32'(evt_pulse), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // First toggle: pulse one cycle after capture edge + 1, counters at +2.
        tog_in = 1'b1;
        tick(1);
        check_eq("t1.pulse_k", 32'(evt_pulse), 32'd0);
        tick(1);
        check_eq("t1.pulse_k1", 32'(evt_pulse), 32'd1);
        check_eq("t1.level", 32'(tog_level), 32'd1);
        check_eq("t1.pend_k1", 32'(pend_cnt), 32'd0);
        tick(1);
        check_eq("t1.pulse_k2", 32'(evt_pulse), 32'd0);
        check_outs("t1", 4'd1, 8'd1, 1'b0);

        // Three more toggles, then drain with ready held high.
        for (int i = 0; i < 3; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        check_outs("t2.queued", 4'd4, 8'd4, 1'b0);
        evt_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick(1);
            check_outs($sformatf("t2.drain%0d", i), 4'(i), 8'd4, 1'b0);
        end
        evt_ready = 1'b0;

        // Saturation and sticky overflow, then clr.
        clr = 1'b1; tick(1); clr = 1'b0;
        check_outs("t3.clr0", 4'd0, 8'd0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            tog_in = ~tog_in;
            tick(4);
            if (i == 15) check_outs("t3.at15", 4'd15, 8'd15, 1'b0);
            if (i == 16) check_outs("t3.at16", 4'd15, 8'd16, 1'b1);
        end
        check_outs("t3.at17", 4'd15, 8'd17, 1'b1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check_outs("t3.clr", 4'd0, 8'd0, 1'b0);

        // Full queue with simultaneous inc and dec.
        for (int i = 0; i < 15; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        check_outs("t4.full", 4'd15, 8'd15, 1'b0);
        tog_in = ~tog_in;
        tick(2);
        check_eq("t4.pulse", 32'(evt_pulse), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check_outs("t4.both", 4'd15, 8'd16, 1'b0);

        // clr coincident with the pulse discards the event.
        clr = 1'b1; tick(1); clr = 1'b0;
        tog_in = ~tog_in;
        tick(2);
        check_eq("t5.pulse", 32'(evt_pulse), 32'd1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check_outs("t5.clr", 4'd0, 8'd0, 1'b0);
        tick(1);
        tog_in = ~tog_in;
        tick(3);
        check_outs("t5.after", 4'd1, 8'd1, 1'b0);

        // Mid-queue reset with the line high, one event after release.
        for (int i = 0; i < 2; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
        check_outs("t6.pre", 4'd3, 8'd3, 1'b0);
        tog_in = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_outs("t6.async", 4'd0, 8'd0, 1'b0);
        check_eq("t6.level", 32'(tog_level), 32'd0);
        check_eq("t6.pulse", 32'(evt_pulse), 32'd0);
        tick(3);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (evt_pulse) pulses++;
        end
        check_eq("t6.npulse", 32'(pulses), 32'd1);
        check_outs("t6.post", 4'd1, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
